hazard_control: RTL and testbench
=================================

HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 2, giving the number of squash cycles after a taken branch (legal range 1..7).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the stall-counter width.
REQ-003 The block SHALL use one clock and a synchronous active-high reset, with ports as follows (clock and reset first).
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 instruction  in  32  instruction currently in ID; opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
REQ-007 branch_taken  in  1  PC-redirect indication from the PC enable logic, valid in the cycle the redirect occurs.
REQ-008 nop  out  1  zeroes all control signals generated for the ID instruction this cycle.
REQ-009 stall  out  1  holds PC and the IF/ID register this cycle.
REQ-010 flush  out  1  clears the IF/ID register to a NOP at the next edge.
REQ-011 stall_count  out  CNT_W  saturating count of cycles with stall=1.

Function
REQ-012 Decode of instruction SHALL be combinational:
- wr = (~op[5] | op[4] | op[2]) & op[1] & op[0]
- uses_rs1 = 0 for opcode 0110111, 0010111 and 1101111; 1 otherwise.
- uses_rs2 = 1 for opcode 0110011, 0100011 and 1100011; 0 otherwise.
REQ-013 The scoreboard SHALL hold two slots, EX (ex_wr, ex_rd) and MEM (mem_wr, mem_rd).
REQ-014 Each cycle, MEM SHALL take EX, and EX SHALL take one of:
- the ID decode (wr, rd) when nop=0;
- a bubble (wr=0, rd=0) when nop=1.
REQ-015 A hazard SHALL exist when, for src in {rs1 if uses_rs1, rs2 if uses_rs2}, src != 0 and src matches the rd of an EX or MEM slot with wr=1.
REQ-016 WB-stage matches SHALL NOT be hazards, because the register file is write-through.
REQ-017 The FSM SHALL have two states: RUN and FLUSH, with a 3-bit flush counter fcnt.
REQ-018 In RUN with branch_taken=1: flush=1, nop=1, stall=0, next state FLUSH, fcnt := FLUSH_CYCLES-1; if FLUSH_CYCLES=1, next state stays RUN.
REQ-019 In RUN with branch_taken=0 and a hazard: stall=1, nop=1, flush=0, state stays RUN.
REQ-020 In RUN with branch_taken=0 and no hazard: stall=0, nop=0, flush=0.
REQ-021 In FLUSH: flush=1, nop=1, stall=0, hazards ignored.
- If branch_taken=1, fcnt reloads to FLUSH_CYCLES-1.
- Otherwise fcnt decrements; fcnt=1 moves to RUN at the next edge.
REQ-022 Flush SHALL take priority over stall when both apply in the same cycle; stall SHALL never assert together with flush.
REQ-023 nop, stall and flush SHALL be combinational from current state, scoreboard, instruction and branch_taken, with zero-cycle latency.
REQ-024 A load-use hazard (EX holds a load to rdX, ID reads rdX) SHALL stall exactly 2 cycles, as SHALL any EX-slot match.
REQ-025 A MEM-only match SHALL stall exactly 1 cycle.
REQ-026 stall_count SHALL increment by 1 on each edge where stall=1 and rst=0, and SHALL hold at 2^CNT_W-1 without wrapping.

Reset
REQ-027 While rst=1 at an edge, the block SHALL load state RUN, fcnt=0, both scoreboard slots to wr=0/rd=0, and stall_count=0.
REQ-028 A reset asserted mid-stall or mid-flush SHALL abort that operation; the first cycle after reset SHALL be RUN with no hazard from prior instructions.
REQ-029 During a reset cycle, outputs SHALL be computed from the post-reset-equivalent state: nop=0, stall=0, flush=0 unless branch_taken=1.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- lw x5,0(x1) then add x6,x5,x7 -> stall=1 and nop=1 for 2 cycles, then the add issues with nop=0; stall_count=2.
- add x5,.. then one independent instruction then sub x8,x5,x9 -> 1 stall cycle on sub.
- Sources x0 (add x0 producer, consumer reads x0) -> no stall.
- branch_taken pulse with FLUSH_CYCLES=2 -> flush=nop=1 for exactly 2 cycles; a second pulse in FLUSH cycle 2 extends by 2 more cycles.
- Hazard and branch_taken in the same cycle -> flush=1, stall=0, stall_count unchanged.
- rst mid-FLUSH and mid-stall -> next cycle RUN, all outputs 0, stall_count=0; stall_count forced near max -> saturates at 0xFFFF.

Source files
------------

// File: rtl/hazard_control_if.sv
// Hazard-control bus: ID instruction and redirect in, pipeline control out.
//   instruction  [31:0]      instruction currently in ID
//   branch_taken             PC redirect in the current cycle
//   nop                      squash control signals of the ID instruction
//   stall                    hold PC and the IF/ID register
//   flush                    clear IF/ID to a NOP at the next edge
//   stall_count  [CNT_W-1:0] saturating count of stalled cycles
// master: pipeline side (drives instruction/branch_taken); slave: hazard_control.
interface hazard_control_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      instruction;
    logic             branch_taken;
    logic             nop;
    logic             stall;
    logic             flush;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output instruction,
        output branch_taken,
        input  nop,
        input  stall,
        input  flush,
        input  stall_count
    );

    modport slave (
        input  instruction,
        input  branch_taken,
        output nop,
        output stall,
        output flush,
        output stall_count
    );
endinterface

// File: rtl/hazard_control.sv
// Pipeline hazard control: two-slot (EX/MEM) destination scoreboard for
// RAW stall detection, plus a RUN/FLUSH FSM that squashes the front end for
// FLUSH_CYCLES cycles after a taken branch.
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   hazard_control_if.slave (instruction/branch_taken in;
//         nop/stall/flush combinational out; stall_count registered out)
module hazard_control #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_control_if.slave  bus
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned FCNT_W = 3;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic               ex_wr_q, mem_wr_q;
    logic [REG_W-1:0]   ex_rd_q, mem_rd_q;
    logic [CNT_W-1:0]   stall_count_q;

    logic [6:0]         op;
    logic [REG_W-1:0]   id_rd, id_rs1, id_rs2;
    logic               id_wr, uses_rs1, uses_rs2;
    logic               hazard_c;
    logic               nop_c, stall_c, flush_c;
    logic               unused_instr_bits;

    // ID decode
    assign op       = bus.instruction[6:0];
    assign id_rd    = bus.instruction[11:7];
    assign id_rs1   = bus.instruction[19:15];
    assign id_rs2   = bus.instruction[24:20];
    assign id_wr    = (~op[5] | op[4] | op[2]) & op[1] & op[0];
    assign uses_rs1 = (op != OP_LUI) && (op != OP_AUIPC) && (op != OP_JAL);
    assign uses_rs2 = (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);

    assign unused_instr_bits = ^{bus.instruction[31:25], bus.instruction[14:12]};

    // RAW check against EX and MEM; x0 never matches, WB is write-through
    function automatic logic src_hit(input logic [REG_W-1:0] src,
                                     input logic ex_wr, input logic [REG_W-1:0] ex_rd,
                                     input logic mem_wr, input logic [REG_W-1:0] mem_rd);
        return (src != '0) && ((ex_wr && (ex_rd == src)) || (mem_wr && (mem_rd == src)));
    endfunction

    assign hazard_c = (uses_rs1 && src_hit(id_rs1, ex_wr_q, ex_rd_q, mem_wr_q, mem_rd_q)) ||
                      (uses_rs2 && src_hit(id_rs2, ex_wr_q, ex_rd_q, mem_wr_q, mem_rd_q));

    // Next-state and control outputs; under rst the outputs reflect the
    // post-reset state (RUN, empty scoreboard)
    always_comb begin
        nop_c   = 1'b0;
        stall_c = 1'b0;
        flush_c = 1'b0;
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (rst) begin
            if (bus.branch_taken) begin
                flush_c = 1'b1;
                nop_c   = 1'b1;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.branch_taken) begin
                        flush_c = 1'b1;
                        nop_c   = 1'b1;
                        fcnt_d  = FCNT_RELOAD;
                        state_d = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
                    end else if (hazard_c) begin
                        stall_c = 1'b1;
                        nop_c   = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    flush_c = 1'b1;
                    nop_c   = 1'b1;
                    if (bus.branch_taken) begin
                        fcnt_d = FCNT_RELOAD;
                    end else begin
                        fcnt_d = fcnt_q - FCNT_W'(1);
                        // <= 1 also recovers from an unreachable fcnt=0
                        if (fcnt_q <= FCNT_W'(1)) begin
                            state_d = ST_RUN;
                        end
                    end
                end
            endcase
        end
    end

    // State, scoreboard shift and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            fcnt_q        <= '0;
            ex_wr_q       <= 1'b0;
            ex_rd_q       <= '0;
            mem_wr_q      <= 1'b0;
            mem_rd_q      <= '0;
            stall_count_q <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            mem_wr_q <= ex_wr_q;
            mem_rd_q <= ex_rd_q;
            ex_wr_q  <= nop_c ? 1'b0 : id_wr;
            ex_rd_q  <= nop_c ? REG_W'(0) : id_rd;
            if (stall_c && (stall_count_q != CNT_MAX)) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
        end
    end

    assign bus.nop         = nop_c;
    assign bus.stall       = stall_c;
    assign bus.flush       = flush_c;
    assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control: load-use, MEM-only match, x0 sources,
// source-usage decode, branch flush and extension, flush/stall priority,
// mid-operation reset and counter saturation (narrow-counter instance).
module tb_hazard_control;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [2:0] obs;

    hazard_control_if #(.CNT_W(16)) bus ();
    hazard_control_if #(.CNT_W(4))  bus2 ();

    hazard_control #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    hazard_control #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, op};
    endfunction

    logic [31:0] i_nop, i_lw5, i_add657, i_add555;

    // Apply one ID cycle at the falling edge; outputs settle 1 time unit later
    task automatic cyc(input logic [31:0] ins, input logic bt, input logic r);
        @(negedge clk);
        rst              = r;
        bus.instruction  = ins;
        bus.branch_taken = bt;
        #1;
        obs = {bus.nop, bus.stall, bus.flush};
    endtask

    task automatic do_reset();
        cyc(i_nop, 1'b0, 1'b1);
    endtask

    // {nop,stall,flush} encoding used below: 000 idle, 110 stall, 101 flush
    task automatic test_reset();
        cyc(i_add657, 1'b0, 1'b1);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL rst_outputs got %b want 000", obs); end
        cyc(i_nop, 1'b1, 1'b1);
        vectors++; if (obs !== 3'b101) begin miscompares++; $display("FAIL rst_branch got %b want 101", obs); end
        cyc(i_nop, 1'b0, 1'b0);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL rst_release got %b want 000", obs); end
        vectors++; if (bus.stall_count !== 16'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", bus.stall_count); end
    endtask

    task automatic test_load_use();
        do_reset();
        cyc(i_lw5, 1'b0, 1'b0);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL lu_lw got %b want 000", obs); end
        cyc(i_add657, 1'b0, 1'b0);
        vectors++; if (obs !== 3'b110) begin miscompares++; $display("FAIL lu_stall1 got %b want 110", obs); end
        cyc(i_add657, 1'b0, 1'b0);
        vectors++; if (obs !== 3'b110) begin miscompares++; $display("FAIL lu_stall2 got %b want 110", obs); end
        cyc(i_add657, 1'b0, 1'b0);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL lu_issue got %b want 000", obs); end
        vectors++; if (bus.stall_count !== 16'd2) begin miscompares++; $display("FAIL lu_count got %0d want 2", bus.stall_count); end
    endtask

    task automatic test_mem_match();
        do_reset();
        cyc(enc(OP_OP, 5'd5, 5'd1, 5'd2), 1'b0, 1'b0);
        cyc(enc(OP_IMM, 5'd10, 5'd0, 5'd0), 1'b0, 1'b0);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL mem_indep got %b want 000", obs); end
        cyc(enc(OP_OP, 5'd8, 5'd5, 5'd9), 1'b0, 1'b0);
        vectors++; if (obs !== 3'b110) begin miscompares++; $display("FAIL mem_stall got %b want 110", obs); end
        cyc(enc(OP_OP, 5'd8, 5'd5, 5'd9), 1'b0, 1'b0);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL mem_issue got %b want 000", obs); end
        vectors++; if (bus.stall_count !== 16'd1) begin miscompares++; $display("FAIL mem_count got %0d want 1", bus.stall_count); end
    endtask

    task automatic test_x0();
        do_reset();
        cyc(enc(OP_OP, 5'd0, 5'd1, 5'd2), 1'b0, 1'b0);
        cyc(enc(OP_OP, 5'd3, 5'd0, 5'd0), 1'b0, 1'b0);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL x0_ex got %b want 000", obs); end
        cyc(enc(OP_OP, 5'd4, 5'd0, 5'd0), 1'b0, 1'b0);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL x0_mem got %b want 000", obs); end
    endtask

    // lui/addi carry 5 in unused source fields; store rs2 is read; store never writes
    task automatic test_src_usage();
        do_reset();
        cyc(i_lw5, 1'b0, 1'b0);
        cyc(enc(OP_LUI, 5'd11, 5'd5, 5'd5), 1'b0, 1'b0);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL src_lui got %b want 000", obs); end
        cyc(enc(OP_IMM, 5'd12, 5'd0, 5'd5), 1'b0, 1'b0);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL src_imm got %b want 000", obs); end
        cyc(enc(OP_STORE, 5'd7, 5'd0, 5'd11), 1'b0, 1'b0);
        vectors++; if (obs !== 3'b110) begin miscompares++; $display("FAIL src_store_rs2 got %b want 110", obs); end
        cyc(enc(OP_STORE, 5'd7, 5'd0, 5'd11), 1'b0, 1'b0);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL src_store_issue got %b want 000", obs); end
        cyc(enc(OP_OP, 5'd3, 5'd7, 5'd0), 1'b0, 1'b0);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL src_store_nowr got %b want 000", obs); end
    endtask

    task automatic test_flush();
        do_reset();
        cyc(i_nop, 1'b1, 1'b0);
        vectors++; if (obs !== 3'b101) begin miscompares++; $display("FAIL fl_c0 got %b want 101", obs); end
        cyc(i_nop, 1'b0, 1'b0);
        vectors++; if (obs !== 3'b101) begin miscompares++; $display("FAIL fl_c1 got %b want 101", obs); end
        cyc(i_nop, 1'b0, 1'b0);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL fl_end got %b want 000", obs); end
        cyc(i_lw5, 1'b0, 1'b0);
        cyc(i_add657, 1'b1, 1'b0);
        vectors++; if (obs !== 3'b101) begin miscompares++; $display("FAIL fl2_c0 got %b want 101", obs); end
        // second pulse in flush cycle 2 reloads; MEM hazard is ignored here
        cyc(i_add657, 1'b1, 1'b0);
        vectors++; if (obs !== 3'b101) begin miscompares++; $display("FAIL fl2_repulse got %b want 101", obs); end
        cyc(i_add657, 1'b0, 1'b0);
        vectors++; if (obs !== 3'b101) begin miscompares++; $display("FAIL fl2_ext got %b want 101", obs); end
        cyc(i_add657, 1'b0, 1'b0);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL fl2_end got %b want 000", obs); end
        vectors++; if (bus.stall_count !== 16'd0) begin miscompares++; $display("FAIL fl_count got %0d want 0", bus.stall_count); end
    endtask

    task automatic test_hazard_branch();
        do_reset();
        cyc(i_lw5, 1'b0, 1'b0);
        cyc(i_add657, 1'b1, 1'b0);
        vectors++; if (obs !== 3'b101) begin miscompares++; $display("FAIL hb_prio got %b want 101", obs); end
        cyc(i_add657, 1'b0, 1'b0);
        vectors++; if (obs !== 3'b101) begin miscompares++; $display("FAIL hb_flush2 got %b want 101", obs); end
        vectors++; if (bus.stall_count !== 16'd0) begin miscompares++; $display("FAIL hb_count got %0d want 0", bus.stall_count); end
        cyc(i_add657, 1'b0, 1'b0);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL hb_run got %b want 000", obs); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(i_lw5, 1'b0, 1'b0);
        cyc(i_add657, 1'b0, 1'b0);
        vectors++; if (obs !== 3'b110) begin miscompares++; $display("FAIL rm_stall got %b want 110", obs); end
        cyc(i_add657, 1'b0, 1'b1);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL rm_stall_rst got %b want 000", obs); end
        vectors++; if (bus.stall_count !== 16'd1) begin miscompares++; $display("FAIL rm_count_pre got %0d want 1", bus.stall_count); end
        cyc(i_add657, 1'b0, 1'b0);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL rm_stall_after got %b want 000", obs); end
        vectors++; if (bus.stall_count !== 16'd0) begin miscompares++; $display("FAIL rm_count got %0d want 0", bus.stall_count); end
        cyc(i_nop, 1'b1, 1'b0);
        cyc(i_nop, 1'b0, 1'b1);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL rm_flush_rst got %b want 000", obs); end
        cyc(i_nop, 1'b0, 1'b0);
        vectors++; if (obs !== 3'b000) begin miscompares++; $display("FAIL rm_flush_after got %b want 000", obs); end
    endtask

    // add x5,x5,x5 held in ID: issue, stall, stall repeating -> 2 stalls per 3 cycles
    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        rst              = 1'b0;
        bus.instruction  = i_nop;
        bus2.instruction = i_add555;
        repeat (21) @(negedge clk);
        #1;
        vectors++; if (bus2.stall_count !== 4'hE) begin miscompares++; $display("FAIL sat_pre got %0d want 14", bus2.stall_count); end
        repeat (9) @(negedge clk);
        #1;
        vectors++; if (bus2.stall_count !== 4'hF) begin miscompares++; $display("FAIL sat_hold got %0d want 15", bus2.stall_count); end
        bus2.instruction = i_nop;
    endtask

    initial begin
        i_nop    = enc(OP_IMM, 5'd0, 5'd0, 5'd0);
        i_lw5    = enc(OP_LOAD, 5'd5, 5'd1, 5'd0);
        i_add657 = enc(OP_OP, 5'd6, 5'd5, 5'd7);
        i_add555 = enc(OP_OP, 5'd5, 5'd5, 5'd5);
        bus.instruction   = i_nop;
        bus.branch_taken  = 1'b0;
        bus2.instruction  = i_nop;
        bus2.branch_taken = 1'b0;

        test_reset();
        test_load_use();
        test_mem_match();
        test_x0();
        test_src_usage();
        test_flush();
        test_hazard_branch();
        test_reset_mid();
        test_saturation();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
